// File: rtl/snail_scan_arbiter.sv
// snail_scan_arbiter
//   Shares one serial "snail" edge detector between two requesters. A
//   round-robin arbiter grants one requester at a time. The granted W-bit
//   word is captured and shifted out LSB first, and the 0->1 transitions in
//   it are counted. The result is returned with the owner id and a one-cycle
//   done pulse.
//
// Parameters
//   W      word width in bits (W >= 2)
//   CW     count width, $clog2(W)+1 (derived)
//
// Ports
//   clk    system clock, rising edge
//   _rst   asynchronous reset, active low
//   req    req[r] high: requester r holds a word on data<r> until ack[r]
//   data0  word of requester 0
//   data1  word of requester 1
//   ack    registered one-cycle pulse; the word of requester r was captured
//   busy   high while a word is being scanned or its result is being shown
//   done   one-cycle pulse; count and owner are valid
//   owner  id of the requester whose result is shown
//   count  number of 0->1 transitions in the last scanned word
//   d_ser  serial bit presented to the detector; 0 outside the scan
module snail_scan_arbiter #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          _rst,
  input  logic [1:0]    req,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  output logic [1:0]    ack,
  output logic          busy,
  output logic          done,
  output logic          owner,
  output logic [CW-1:0] count,
  output logic          d_ser
);

  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  sreg;
  logic [IW-1:0] idx;
  logic          prev;
  logic          last;

  logic          gnt_any;
  logic          gnt_id;

  // Round-robin choice: a lone requester always wins; on a tie the one that
  // was not granted last time wins.
  always_comb begin
    gnt_any = |req;
    gnt_id  = (&req) ? ~last : req[1];
  end

  always_comb begin
    d_ser = (state == SHIFT) ? sreg[0] : 1'b0;
    busy  = (state != IDLE);
    done  = (state == DONE);
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state <= IDLE;
      ack   <= '0;
      owner <= 1'b0;
      count <= '0;
      sreg  <= '0;
      idx   <= '0;
      prev  <= 1'b0;
      last  <= 1'b1;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            sreg  <= gnt_id ? data1 : data0;
            idx   <= '0;
            prev  <= 1'b0;
            count <= '0;
            owner <= gnt_id;
            last  <= gnt_id;
            ack   <= gnt_id ? 2'b10 : 2'b01;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Bit 0 has no predecessor in the word, so it never counts.
          if ((idx != '0) && !prev && d_ser)
            count <= count + CW'(1);
          prev <= d_ser;
          sreg <= sreg >> 1;
          // idx parks at W-1 instead of wrapping when W is a power of two.
          if (idx == IW'(W - 1))
            state <= DONE;
          else
            idx <= idx + IW'(1);
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snail_scan_arbiter.sv
module tb_snail_scan_arbiter;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          _rst;
  logic [1:0]    req;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [1:0]    ack;
  logic          busy;
  logic          done;
  logic          owner;
  logic [CW-1:0] count;
  logic          d_ser;

  int      checks = 0;
  int      errors = 0;
  logic    m_last;
  longint  cyc = 0;
  longint  t_ack;
  longint  t_prev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snail_scan_arbiter #(.W(W)) dut (
    .clk   (clk),
    ._rst  (_rst),
    .req   (req),
    .data0 (data0),
    .data1 (data1),
    .ack   (ack),
    .busy  (busy),
    .done  (done),
    .owner (owner),
    .count (count),
    .d_ser (d_ser)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: number of positions i>0 where bit i is 1 and bit i-1 is 0.
  function automatic int trans01(input logic [W-1:0] w);
    int n = 0;
    for (int i = 1; i < W; i++)
      if (w[i] && !w[i-1]) n++;
    return n;
  endfunction

  function automatic int pick(input logic [1:0] r, input logic l);
    if (r == 2'b11) return l ? 0 : 1;
    return r[1] ? 1 : 0;
  endfunction

  task automatic raise(input int rid);
    if (!req[rid]) begin
      req[rid] = 1'b1;
      if (rid == 1) data1 = W'($urandom);
      else          data0 = W'($urandom);
    end
  endtask

  // One full transaction: wait for the grant, follow the serial stream,
  // check the result and its hold cycle. Returns on the cycle after done.
  task automatic serve(input logic keep, input int raise_id, input int raise_at);
    int           gid;
    int           n;
    int           k;
    logic [1:0]   exp_ack;
    logic [W-1:0] word;
    gid     = pick(req, m_last);
    exp_ack = (gid == 1) ? 2'b10 : 2'b01;
    word    = (gid == 1) ? data1 : data0;
    n       = trans01(word);
    k       = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ack == 2'b00 && k < 40);
    chk("ack", ack, exp_ack);
    t_ack  = cyc;
    m_last = gid[0];
    chk("busy_shift", busy, 1);
    chk("dser_bit0", d_ser, word[0]);
    if (keep) begin
      if (gid == 1) data1 = W'($urandom);
      else          data0 = W'($urandom);
    end else begin
      req[gid] = 1'b0;
    end
    if (raise_at == 0) raise(raise_id);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      chk("dser_bit", d_ser, word[i]);
      chk("done_early", done, 0);
      chk("ack_in_shift", ack, 0);
      if (raise_at == i) raise(raise_id);
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("owner", owner, gid);
    chk("count", count, n);
    chk("dser_done", d_ser, 0);
    chk("busy_done", busy, 1);
    if (raise_at == W) raise(raise_id);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_idle", busy, 0);
    chk("ack_in_done", ack, 0);
    chk("count_hold", count, n);
    chk("owner_hold", owner, gid);
    if (raise_at == W + 1) raise(raise_id);
  endtask

  logic [W-1:0] words [4] = '{8'hAA, 8'hFF, 8'h00, 8'h80};
  int           wexp  [4] = '{4, 0, 0, 1};

  initial begin
    // 1: reset held with both requests up
    _rst  = 1'b0;
    req   = 2'b11;
    data0 = W'($urandom);
    data1 = W'($urandom);
    m_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_owner", owner, 0);
    chk("rst_dser", d_ser, 0);
    _rst = 1'b1;
    serve(1'b0, 0, -1);
    serve(1'b0, 0, -1);

    // 2: 0x55 gives three transitions
    data0 = 8'h55;
    req   = 2'b01;
    serve(1'b0, 0, -1);
    chk("count_55", count, 3);

    // 3: fixed boundary words
    for (int j = 0; j < 4; j++) begin
      data0 = words[j];
      req   = 2'b01;
      serve(1'b0, 0, -1);
      chk("count_fixed", count, wexp[j]);
    end

    // 5: req1 arrives mid-scan and waits for the IDLE edge after DONE
    data0 = W'($urandom);
    req   = 2'b01;
    serve(1'b0, 1, 3);
    serve(1'b0, 0, -1);
    chk("owner_late", owner, 1);

    // 4: both requesters re-arm continuously; grants alternate every W+2 cycles
    req   = 2'b11;
    data0 = W'($urandom);
    data1 = W'($urandom);
    serve(1'b1, 0, -1);
    for (int j = 0; j < 3; j++) begin
      t_prev = t_ack;
      serve(1'b1, 0, -1);
      chk("b2b_spacing", 32'(t_ack - t_prev), W + 2);
    end
    req = 2'b00;

    // 6: reset at idx 3 aborts the scan, pending request re-granted afterwards
    data1 = {W'($urandom)} & 8'hF8 | 8'h05;
    req   = 2'b10;
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (ack == 2'b00 && k < 40);
    end
    chk("ack_pre_rst", ack, 2'b10);
    repeat (3) @(negedge clk);
    _rst = 1'b0;
    #1;
    chk("arst_ack", ack, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", count, 0);
    chk("arst_owner", owner, 0);
    chk("arst_dser", d_ser, 0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    _rst   = 1'b1;
    m_last = 1'b1;
    serve(1'b0, 0, -1);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      if (req == 2'b00) begin
        req   = 2'($urandom_range(1, 3));
        data0 = W'($urandom);
        data1 = W'($urandom);
      end
      serve(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, W + 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
